// File: rtl/eqchk_pkg.sv
// ---------------------------------------------------------------------------
// eqchk_pkg
// Shared definitions for the equality-checker stimulus generator:
//   - state_e          : sequencer states
//   - LFSR_TAPS        : tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   - FIRST_FAIL_NONE  : FIRST_FAIL value meaning "no failing vector yet"
//   - lfsr_next()      : one Fibonacci shift step
// ---------------------------------------------------------------------------
package eqchk_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StDrive,
      StWait,
      StSample,
      StFinish
   } state_e;

   localparam logic [7:0] LFSR_TAPS       = 8'hB8;
   localparam logic [7:0] FIRST_FAIL_NONE = 8'hFF;

   // Shift left; the new bit 0 is the XOR of the tapped bits.
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/eqchk_lfsr8.sv
// ---------------------------------------------------------------------------
// eqchk_lfsr8
// 8-bit Fibonacci LFSR used as the operand source for the stimulus generator.
// Ports:
//   i_clk    in  1  rising-edge clock
//   i_rst    in  1  asynchronous active-high reset (state returns to SEED)
//   i_load   in  1  reload SEED (has priority over i_adv)
//   i_adv    in  1  advance one step
//   o_state  out 8  current LFSR value
// ---------------------------------------------------------------------------
module eqchk_lfsr8 #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  logic       i_adv,
   output logic [7:0] o_state
);
   import eqchk_pkg::*;

   logic [7:0] r_lfsr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lfsr <= SEED;
      end else if (i_load) begin
         r_lfsr <= SEED;
      end else if (i_adv) begin
         r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   assign o_state = r_lfsr;

endmodule

// File: rtl/equality_checker_stim_gen.sv
// ---------------------------------------------------------------------------
// equality_checker_stim_gen
// Self-test driver for the 8-bit equality checker. On START it drives NUM_VEC
// operand pairs (equal on even vectors, one bit different on odd vectors),
// waits SETTLE_CYC cycles per vector, samples the checker's result and keeps
// a mismatch scoreboard.
// Ports:
//   i_clk         in  1      rising-edge clock
//   i_rst         in  1      asynchronous active-high reset
//   i_start       in  1      run request, level, sampled only in IDLE/FINISH
//   i_eq_in       in  1      checker result, sampled only in SAMPLE
//   o_a, o_b      out WIDTH  registered operands to the checker
//   o_busy        out 1      run in progress
//   o_done        out 1      run complete, held until next accepted start
//   o_pass        out 1      done with zero mismatches
//   o_fail_cnt    out 8      saturating mismatch count
//   o_first_fail  out 8      index of first failing vector, 8'hFF if none
// ---------------------------------------------------------------------------
module equality_checker_stim_gen #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned NUM_VEC    = 32,
   parameter int unsigned SETTLE_CYC = 2,
   parameter logic [7:0]  SEED       = 8'hA5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_eq_in,
   output logic [WIDTH-1:0] o_a,
   output logic [WIDTH-1:0] o_b,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [7:0]       o_fail_cnt,
   output logic [7:0]       o_first_fail
);
   import eqchk_pkg::*;

   localparam logic [7:0] LAST_VEC    = 8'(NUM_VEC - 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

   state_e           r_state;
   logic [7:0]       r_vec;
   logic [7:0]       r_settle;
   logic             r_exp;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_busy;
   logic             r_done;
   logic [7:0]       r_fail_cnt;
   logic [7:0]       r_first_fail;

   logic [7:0]       w_lfsr;
   logic             w_accept;
   logic             w_adv;
   int unsigned      w_flip_idx;
   logic [WIDTH-1:0] w_flip_mask;

   // A run can only be (re)started from IDLE or FINISH; START while busy is ignored.
   assign w_accept = ((r_state == StIdle) || (r_state == StFinish)) && i_start;
   assign w_adv    = (r_state == StSample);

   always_comb begin
      w_flip_idx  = 32'(r_vec) % WIDTH;
      w_flip_mask = WIDTH'(1) << w_flip_idx;
   end

   eqchk_lfsr8 #(
      .SEED (SEED)
   ) u_lfsr (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_accept),
      .i_adv   (w_adv),
      .o_state (w_lfsr)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_vec        <= 8'd0;
         r_settle     <= 8'd0;
         r_exp        <= 1'b0;
         r_a          <= '0;
         r_b          <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_fail_cnt   <= 8'd0;
         r_first_fail <= FIRST_FAIL_NONE;
      end else begin
         case (r_state)
            StIdle, StFinish: begin
               if (i_start) begin
                  r_fail_cnt   <= 8'd0;
                  r_first_fail <= FIRST_FAIL_NONE;
                  r_vec        <= 8'd0;
                  r_done       <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= StDrive;
               end
            end
            StDrive: begin
               r_a      <= WIDTH'(w_lfsr);
               // Odd vectors flip one bit so the checker must report "not equal".
               r_b      <= r_vec[0] ? (WIDTH'(w_lfsr) ^ w_flip_mask) : WIDTH'(w_lfsr);
               r_exp    <= ~r_vec[0];
               r_settle <= 8'd0;
               r_state  <= StWait;
            end
            StWait: begin
               if (r_settle == SETTLE_LAST) begin
                  r_state <= StSample;
               end else begin
                  r_settle <= r_settle + 8'd1;
               end
            end
            StSample: begin
               if (i_eq_in != r_exp) begin
                  if (r_fail_cnt != 8'hFF) begin
                     r_fail_cnt <= r_fail_cnt + 8'd1;
                  end
                  if (r_first_fail == FIRST_FAIL_NONE) begin
                     r_first_fail <= r_vec;
                  end
               end
               r_vec <= r_vec + 8'd1;
               if (r_vec == LAST_VEC) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= StFinish;
               end else begin
                  r_state <= StDrive;
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_a          = r_a;
   assign o_b          = r_b;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_pass       = r_done && (r_fail_cnt == 8'd0);
   assign o_fail_cnt   = r_fail_cnt;
   assign o_first_fail = r_first_fail;

endmodule
